axi_addr_4k_splitter: RTL and testbench

Address-channel splitter that sits directly upstream of the AXI master port. It accepts one burst request per handshake (ID, address, length, size, burst type) and emits one or more AXI address-phase pieces (AW or AR). No piece crosses a 4KB boundary, so the downstream interface's 4KB-boundary and address-stability checks always hold. Each piece carries a `m_last` flag so the response merger can recombine responses per original request. One instance is used per address channel.

---
 rtl/axi_addr_4k_splitter.sv | 169 ++++++++++++++++
 tb/tb_axi_addr_4k_splitter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_addr_4k_splitter.sv
// Splits AXI address-phase requests into pieces that never cross a 4KB page.
// INCR bursts are cut at page boundaries; FIXED and WRAP pass through as a single piece.
module axi_addr_4k_splitter #(
    parameter int unsigned ID_WIDTH    = 4,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned LEN_WIDTH   = 8,
    parameter int unsigned SIZE_WIDTH  = 3,
    parameter int unsigned BURST_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [ID_WIDTH-1:0]    s_id,
    input  logic [ADDR_WIDTH-1:0]  s_addr,
    input  logic [LEN_WIDTH-1:0]   s_len,
    input  logic [SIZE_WIDTH-1:0]  s_size,
    input  logic [BURST_WIDTH-1:0] s_burst,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [ID_WIDTH-1:0]    m_id,
    output logic [ADDR_WIDTH-1:0]  m_addr,
    output logic [LEN_WIDTH-1:0]   m_len,
    output logic [SIZE_WIDTH-1:0]  m_size,
    output logic [BURST_WIDTH-1:0] m_burst,
    output logic                   m_last
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    localparam int unsigned REM_W  = LEN_WIDTH + 1;
    localparam int unsigned CMP_W  = (REM_W > 13) ? REM_W : 13;
    localparam int unsigned PAGE_W = ADDR_WIDTH - 12;

    localparam logic [BURST_WIDTH-1:0] BURST_INCR = BURST_WIDTH'(1);

    // Request context
    logic [0:0]             state_q,    state_d;
    logic [ID_WIDTH-1:0]    id_q,       id_d;
    logic [SIZE_WIDTH-1:0]  size_q,     size_d;
    logic [BURST_WIDTH-1:0] burst_q,    burst_d;
    logic [ADDR_WIDTH-1:0]  cur_addr_q, cur_addr_d;
    logic [REM_W-1:0]       rem_q,      rem_d;

    // Registered piece presented downstream
    logic                   m_valid_q, m_valid_d;
    logic [ID_WIDTH-1:0]    m_id_q,    m_id_d;
    logic [ADDR_WIDTH-1:0]  m_addr_q,  m_addr_d;
    logic [LEN_WIDTH-1:0]   m_len_q,   m_len_d;
    logic [SIZE_WIDTH-1:0]  m_size_q,  m_size_d;
    logic [BURST_WIDTH-1:0] m_burst_q, m_burst_d;
    logic                   m_last_q,  m_last_d;

    logic                   hs;
    logic                   accept;
    logic [11:0]            lo_mask;
    logic [11:0]            aligned_lo;
    logic [12:0]            page_beats;
    logic                   split;
    logic [LEN_WIDTH-1:0]   piece_len;

    // A new request may ride on the final handshake of the previous one.
    assign s_ready = !rst && ((state_q == ST_IDLE) || (m_valid_q && m_ready && m_last_q));
    assign accept  = s_valid && s_ready;
    assign hs      = m_valid_q && m_ready;

    assign m_valid = m_valid_q;
    assign m_id    = m_id_q;
    assign m_addr  = m_addr_q;
    assign m_len   = m_len_q;
    assign m_size  = m_size_q;
    assign m_burst = m_burst_q;
    assign m_last  = m_last_q;

    // Next request context: advance to the next page on a non-final handshake, reload on accept.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        size_d     = size_q;
        burst_d    = burst_q;
        cur_addr_d = cur_addr_q;
        rem_d      = rem_q;

        if (hs) begin
            if (m_last_q) begin
                state_d = ST_IDLE;
            end else begin
                cur_addr_d = {cur_addr_q[ADDR_WIDTH-1:12] + PAGE_W'(1), 12'h000};
                rem_d      = rem_q - (REM_W'(m_len_q) + REM_W'(1));
            end
        end

        if (accept) begin
            state_d    = ST_EMIT;
            id_d       = s_id;
            size_d     = s_size;
            burst_d    = s_burst;
            cur_addr_d = s_addr;
            rem_d      = REM_W'(s_len) + REM_W'(1);
        end
    end

    // Piece shape for the upcoming context, so the outputs can be registered.
    always_comb begin
        lo_mask    = 12'hFFF << size_d;
        aligned_lo = cur_addr_d[11:0] & lo_mask;
        page_beats = (13'h1000 - {1'b0, aligned_lo}) >> size_d;
        split      = (burst_d == BURST_INCR) && (CMP_W'(rem_d) > CMP_W'(page_beats));
        piece_len  = split ? LEN_WIDTH'(page_beats - 13'd1)
                           : LEN_WIDTH'(rem_d - REM_W'(1));
    end

    // Output register load: only when the presented piece changes hands or a request arrives.
    always_comb begin
        m_valid_d = m_valid_q;
        m_id_d    = m_id_q;
        m_addr_d  = m_addr_q;
        m_len_d   = m_len_q;
        m_size_d  = m_size_q;
        m_burst_d = m_burst_q;
        m_last_d  = m_last_q;

        if (hs || accept) begin
            m_valid_d = (state_d == ST_EMIT);
            if (state_d == ST_EMIT) begin
                m_id_d    = id_d;
                m_addr_d  = cur_addr_d;
                m_len_d   = piece_len;
                m_size_d  = size_d;
                m_burst_d = burst_d;
                m_last_d  = !split;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            id_q       <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            cur_addr_q <= '0;
            rem_q      <= '0;
            m_valid_q  <= 1'b0;
            m_id_q     <= '0;
            m_addr_q   <= '0;
            m_len_q    <= '0;
            m_size_q   <= '0;
            m_burst_q  <= '0;
            m_last_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            cur_addr_q <= cur_addr_d;
            rem_q      <= rem_d;
            m_valid_q  <= m_valid_d;
            m_id_q     <= m_id_d;
            m_addr_q   <= m_addr_d;
            m_len_q    <= m_len_d;
            m_size_q   <= m_size_d;
            m_burst_q  <= m_burst_d;
            m_last_q   <= m_last_d;
        end
    end

endmodule

// File: tb/tb_axi_addr_4k_splitter.sv
// Bench for axi_addr_4k_splitter: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a byte-address page model.
module tb_axi_addr_4k_splitter;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [3:0]  s_id;
    logic [31:0] s_addr;
    logic [7:0]  s_len;
    logic [2:0]  s_size;
    logic [1:0]  s_burst;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  m_id;
    logic [31:0] m_addr;
    logic [7:0]  m_len;
    logic [2:0]  m_size;
    logic [1:0]  m_burst;
    logic        m_last;

    axi_addr_4k_splitter #(
        .ID_WIDTH(4), .ADDR_WIDTH(32), .LEN_WIDTH(8), .SIZE_WIDTH(3), .BURST_WIDTH(2)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_id(s_id), .s_addr(s_addr),
        .s_len(s_len), .s_size(s_size), .s_burst(s_burst),
        .m_valid(m_valid), .m_ready(m_ready), .m_id(m_id), .m_addr(m_addr),
        .m_len(m_len), .m_size(m_size), .m_burst(m_burst), .m_last(m_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        last;
    } piece_t;

    typedef struct {
        string       name;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          exp_n;
        logic [31:0] a0;
        logic [7:0]  l0;
        logic [31:0] an;
        logic [7:0]  ln;
    } vec_t;

    int     n_checks = 0;
    int     n_fail   = 0;
    piece_t exp_q[$];
    piece_t got_q[$];
    bit     rdy_random = 1'b0;
    piece_t cur_p, prev_p, exp_p;
    bit     stalled = 1'b0;
    vec_t   vecs[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    // Reference: walk the burst in bytes, each piece runs to the end of its 4KB page.
    task automatic model_push(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
        longint a, rem, bpb, room, n;
        piece_t p;
        a   = longint'(addr);
        rem = longint'(len) + 1;
        bpb = longint'(1) << size;
        if (burst != 2'd1) begin
            p = {id, addr, len, size, burst, 1'b1};
            exp_q.push_back(p);
        end else begin
            while (rem > 0) begin
                room = (4096 - ((a % 4096) / bpb) * bpb) / bpb;
                n    = (rem < room) ? rem : room;
                p    = {id, 32'(a), 8'(n - 1), size, burst, (n == rem)};
                exp_q.push_back(p);
                rem  = rem - n;
                a    = (((a / 4096) + 1) * 4096) % 64'h1_0000_0000;
            end
        end
    endtask

    // Scoreboard and output-stability monitor.
    always @(negedge clk) begin
        cur_p = {m_id, m_addr, m_len, m_size, m_burst, m_last};
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("hold_valid", 64'(m_valid), 64'd1);
                check("hold_payload", 64'(cur_p), 64'(prev_p));
            end
            if (m_valid && m_ready) begin
                got_q.push_back(cur_p);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_piece: got 0x%0h required none", cur_p);
                end else begin
                    exp_p = exp_q.pop_front();
                    check("piece", 64'(cur_p), 64'(exp_p));
                end
            end
            stalled = m_valid && !m_ready;
            prev_p  = cur_p;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_random) m_ready = 1'($urandom_range(0, 1));
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst, output int waited);
        bit done;
        bit ok;
        s_valid = 1'b1;
        s_id    = id;
        s_addr  = addr;
        s_len   = len;
        s_size  = size;
        s_burst = burst;
        waited  = 0;
        done    = 1'b0;
        ok      = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (s_ready) begin
                done = 1'b1;
                ok   = 1'b1;
            end else begin
                waited++;
                if (waited > 2000) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL accept_timeout: got no s_ready required accept within 2000 cycles");
                    done = 1'b1;
                end
            end
        end
        if (ok) model_push(id, addr, len, size, burst);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        bit done;
        t    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_valid) begin
                done = 1'b1;
            end else begin
                t++;
                if (t > 3000) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s_drain_timeout: got %0d pending required 0", name, exp_q.size());
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int  w;
        int  w_b2b[3];
        bit  seen;
        logic [31:0] ra;

        vecs[0] = '{"single",    4'h5, 32'h0000_1000, 8'd7,   3'd3, 2'd1, 1, 32'h0000_1000, 8'd7,  32'h0000_1000, 8'd7};
        vecs[1] = '{"two",       4'h3, 32'h0000_0FF0, 8'd7,   3'd3, 2'd1, 2, 32'h0000_0FF0, 8'd1,  32'h0000_1000, 8'd5};
        vecs[2] = '{"unaligned", 4'h2, 32'h0000_0FFE, 8'd3,   3'd2, 2'd1, 2, 32'h0000_0FFE, 8'd0,  32'h0000_1000, 8'd2};
        vecs[3] = '{"multipage", 4'h9, 32'h0000_0800, 8'd255, 3'd7, 2'd1, 9, 32'h0000_0800, 8'd15, 32'h0000_8000, 8'd15};
        vecs[4] = '{"fixed",     4'h6, 32'h0000_0FF8, 8'd3,   3'd3, 2'd0, 1, 32'h0000_0FF8, 8'd3,  32'h0000_0FF8, 8'd3};
        vecs[5] = '{"wrap",      4'h1, 32'h0000_0FF0, 8'd3,   3'd3, 2'd2, 1, 32'h0000_0FF0, 8'd3,  32'h0000_0FF0, 8'd3};
        vecs[6] = '{"addrwrap",  4'hA, 32'hFFFF_FFF0, 8'd7,   3'd3, 2'd1, 2, 32'hFFFF_FFF0, 8'd1,  32'h0000_0000, 8'd5};
        vecs[7] = '{"exactfit",  4'h4, 32'h0000_0F00, 8'd31,  3'd3, 2'd1, 1, 32'h0000_0F00, 8'd31, 32'h0000_0F00, 8'd31};
        vecs[8] = '{"bytewide",  4'hF, 32'h0000_0FFF, 8'd255, 3'd0, 2'd1, 2, 32'h0000_0FFF, 8'd0,  32'h0000_1000, 8'd254};
        vecs[9] = '{"page8",     4'h0, 32'h0000_0000, 8'd255, 3'd7, 2'd1, 8, 32'h0000_0000, 8'd31, 32'h0000_7000, 8'd31};

        rst = 1'b1; s_valid = 1'b0; s_id = '0; s_addr = '0; s_len = '0; s_size = '0; s_burst = '0;
        m_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_m_last",  64'(m_last),  64'd0);
        check("rst_payload", 64'({m_id, m_addr, m_len, m_size, m_burst}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("s_ready_after_rst", 64'(s_ready), 64'd1);
        @(posedge clk); #1;

        // Directed table
        foreach (vecs[i]) begin
            got_q.delete();
            send(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst, w);
            @(negedge clk);
            check({vecs[i].name, "_latency"}, 64'(m_valid), 64'd1);
            drain(vecs[i].name);
            check({vecs[i].name, "_count"}, 64'(got_q.size()), 64'(vecs[i].exp_n));
            if (got_q.size() > 0) begin
                check({vecs[i].name, "_first"}, 64'({got_q[0].id, got_q[0].addr, got_q[0].len}),
                      64'({vecs[i].id, vecs[i].a0, vecs[i].l0}));
                check({vecs[i].name, "_final"}, 64'({got_q[$].addr, got_q[$].len, got_q[$].last}),
                      64'({vecs[i].an, vecs[i].ln, 1'b1}));
            end
        end

        // Back-to-back: each request offered during the previous final handshake
        got_q.delete();
        send(4'h1, 32'h0000_2000, 8'd0, 3'd2, 2'd1, w);
        send(4'h2, 32'h0000_0FF8, 8'd3, 3'd3, 2'd0, w_b2b[0]);
        send(4'h3, 32'h0000_3000, 8'd1, 3'd3, 2'd2, w_b2b[1]);
        send(4'h4, 32'h0000_4000, 8'd2, 3'd1, 2'd1, w_b2b[2]);
        check("b2b_wait0", 64'(w_b2b[0]), 64'd0);
        check("b2b_wait1", 64'(w_b2b[1]), 64'd0);
        check("b2b_wait2", 64'(w_b2b[2]), 64'd0);
        drain("b2b");
        check("b2b_count", 64'(got_q.size()), 64'd4);

        // Backpressure on the first piece of a split
        got_q.delete();
        m_ready = 1'b0;
        send(4'h7, 32'h0000_0FF0, 8'd7, 3'd3, 2'd1, w);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid",   64'(m_valid), 64'd1);
            check("bp_piece",   64'({m_id, m_addr, m_len, m_last}), 64'({4'h7, 32'h0000_0FF0, 8'd1, 1'b0}));
            check("bp_s_ready", 64'(s_ready), 64'd0);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        drain("bp");
        check("bp_count", 64'(got_q.size()), 64'd2);

        // Reset in the middle of a split
        m_ready = 1'b0;
        send(4'h8, 32'h0000_0FF0, 8'd7, 3'd3, 2'd1, w);
        @(negedge clk);
        check("rs_pre_valid", 64'(m_valid), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("rs_s_ready_in_rst", 64'(s_ready), 64'd0);
        @(negedge clk);
        check("rs_valid_drop", 64'(m_valid), 64'd0);
        check("rs_addr_clear", 64'(m_addr), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_ready = 1'b1;
        got_q.delete();
        @(negedge clk);
        check("rs_s_ready_after", 64'(s_ready), 64'd1);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (m_valid) seen = 1'b1;
        end
        check("rs_no_piece2", 64'(seen), 64'd0);
        @(posedge clk); #1;

        // Randomized traffic with random downstream stalls
        rdy_random = 1'b1;
        repeat (200) begin
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra[11:0] = 12'hFFF - 12'($urandom_range(0, 64));
            send(4'($urandom), ra, 8'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 2)), w);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain("rand");
        rdy_random = 1'b0;
        m_ready = 1'b1;
        check("rand_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
